// File: rtl/conv_window_reader_pkg.sv
// Shared constants and state encoding for the 5x5 window read sequencer.
package conv_window_reader_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned IMG_W      = 48;
  localparam int unsigned IMG_H      = 48;
  localparam int unsigned K          = 5;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned OUT_W      = IMG_W - K + 1;
  localparam int unsigned OUT_H      = IMG_H - K + 1;
  localparam int unsigned COORD_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/conv_window_reader_raster_addr_gen.sv
// Raster row/column counters with a row-base accumulator; address = row_base + col.
module raster_addr_gen #(
  parameter int unsigned IMG_W      = 48,
  parameter int unsigned LAST_ROW   = 43,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned COORD_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_step,
  output logic [COORD_W-1:0]    o_row,
  output logic [COORD_W-1:0]    o_col,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_col_last,
  output logic                  o_row_last
);

  logic [COORD_W-1:0]    r_row;
  logic [COORD_W-1:0]    r_col;
  logic [ADDR_WIDTH-1:0] r_row_base;

  assign o_col_last = (r_col == COORD_W'(IMG_W - 1));
  assign o_row_last = (r_row == COORD_W'(LAST_ROW));
  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_addr     = r_row_base + ADDR_WIDTH'(r_col);

  // Advance one pixel per step; the final position of the frame holds until cleared.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_row      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (i_step) begin
      if (o_col_last) begin
        if (!o_row_last) begin
          r_col      <= '0;
          r_row      <= r_row + COORD_W'(1);
          r_row_base <= r_row_base + ADDR_WIDTH'(IMG_W);
        end
      end else begin
        r_col <= r_col + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_reader.sv
// Walks the line buffer in raster order and streams 5x5 windows over valid/ready.
module conv_window_reader #(
  parameter int unsigned DATA_WIDTH = conv_window_reader_pkg::DATA_WIDTH,
  parameter int unsigned IMG_W      = conv_window_reader_pkg::IMG_W,
  parameter int unsigned IMG_H      = conv_window_reader_pkg::IMG_H,
  parameter int unsigned ADDR_WIDTH = conv_window_reader_pkg::ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            buf_ce,
  output logic                            buf_we,
  output logic [ADDR_WIDTH-1:0]           buf_addr,
  input  logic [5*DATA_WIDTH-1:0]         buf_q,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [25*DATA_WIDTH-1:0]        win_data,
  output logic [5:0]                      win_row,
  output logic [5:0]                      win_col,
  output logic                            win_last
);

  import conv_window_reader_pkg::*;

  localparam int unsigned COL_W = K * DATA_WIDTH;
  localparam int unsigned WIN_W = K * COL_W;
  localparam int unsigned CW    = COORD_W;

  state_e             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_win_valid;
  logic               r_win_last;
  logic [WIN_W-1:0]   r_win_data;
  logic [CW-1:0]      r_win_row;
  logic [CW-1:0]      r_win_col;

  logic                  w_cap;
  logic                  w_accept;
  logic                  w_clear;
  logic [CW-1:0]         w_row;
  logic [CW-1:0]         w_col;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_col_last;
  logic                  w_row_last;

  assign w_accept = r_win_valid && win_ready;
  assign w_cap    = ((r_state == ST_FILL) || (r_state == ST_STREAM)) && (!r_win_valid || win_ready);
  assign w_clear  = (r_state == ST_DRAIN) && w_accept;

  raster_addr_gen #(
    .IMG_W      (IMG_W),
    .LAST_ROW   (IMG_H - K),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COORD_W    (CW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_step     (w_cap),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_addr     (w_addr),
    .o_col_last (w_col_last),
    .o_row_last (w_row_last)
  );

  // Sequencer: fill four columns per row, stream the rest, drain the last window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FILL;
            r_busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (w_accept) r_win_valid <= 1'b0;
          if (w_cap && (w_col == CW'(K - 2))) r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          // A stalled window blocks capture, so accept always coincides with a new load.
          if (w_cap) begin
            r_win_valid <= 1'b1;
            r_win_row   <= w_row;
            r_win_col   <= w_col - CW'(K - 1);
            r_win_last  <= w_col_last && w_row_last;
            if (w_col_last) r_state <= w_row_last ? ST_DRAIN : ST_FILL;
          end
        end
        ST_DRAIN: begin
          if (w_accept) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Window shift register: newest column enters at the low end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_data <= '0;
    end else if (w_cap) begin
      r_win_data <= {r_win_data[WIN_W-COL_W-1:0], buf_q};
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign buf_ce    = r_busy;
  assign buf_we    = 1'b0;
  assign buf_addr  = w_addr;
  assign win_valid = r_win_valid;
  assign win_data  = r_win_data;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;
  assign win_last  = r_win_last;

endmodule
